nx_fifo_drain: RTL and testbench
================================

Name: nx_fifo_drain

Overview:
- Read-side consumer for the 2-deep first-word-fall-through nx_fifo. It pops words from the FIFO read port and presents them as a valid/ready stream through a 2-entry output skid buffer.
- It tracks frame boundaries using a per-word last flag, counts beats and frames, and flags FIFO underflow and overlength frames.
- It sits between a FIFO instance and a downstream stream consumer.
- fifo_ren does not depend combinationally on out_ready.

Parameters:
DATA_W, 34, word width; matches FIFO rdata width.
LAST_BIT, 33, bit index of the end-of-frame flag within the word.
MAX_BEATS, 255, maximum legal beats per frame.
CNT_W, 16, frame counter width.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  reset.
fifo_empty  input  1  FIFO empty; rdata is valid when low.
fifo_rdata  input  DATA_W  FIFO head word (fall-through).
fifo_underflow  input  1  FIFO underflow pulse.
fifo_ren  output  1  FIFO pop strobe.
fifo_clear  output  1  FIFO clear, mirrors flush.
flush  input  1  drop all buffered and in-flight data.
out_valid  output  1  stream word available.
out_data  output  DATA_W  stream word (skid head).
out_last  output  1  out_data[LAST_BIT].
out_ready  input  1  downstream accept.
beat_cnt  output  8  beats accepted in the current frame.
frame_cnt  output  CNT_W  completed frames; wraps modulo 2^CNT_W.
err_underflow  output  1  sticky; set by fifo_underflow.
err_overlength  output  1  sticky; frame exceeded MAX_BEATS.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at the edge), all of the following are 0 on the next cycle:
  - skid occupancy (occ), out_valid, out_data, beat_cnt, frame_cnt, err_underflow, err_overlength.
  - fifo_ren is forced to 0 while rst is high.
  - Reset mid-frame discards the buffered words; the FIFO is not cleared unless flush is asserted.
- Pop rule: fifo_ren = !rst && !flush && !fifo_empty && (occ < 2). occ is registered (0..2).
- Capture: on a cycle with fifo_ren high, fifo_rdata is written into the skid tail at that edge.
- Latency: a word that is at the FIFO head at cycle t appears on out_data with out_valid high at t+1 when occ was 0 at t.
- Fire: a beat is accepted when out_valid && out_ready; the head is removed at that edge.
- Simultaneous pop and fire: occ is unchanged and order is preserved.
  - With occ=1, the head is replaced by the captured word.
  - With occ=2, the second entry shifts to the head and the captured word takes the tail.
- Throughput: sustains 1 word/cycle when out_ready is held high and the FIFO stays non-empty.
- Stall: with out_ready low, occ fills to 2, then fifo_ren drops.
- Valid/data hold: out_valid and out_data are held stable until fire; out_valid never deasserts without a fire or flush.
- out_data is 0 whenever out_valid is 0.
- Frame accounting on each fire:
  - Non-last beat: beat_cnt increments, saturating at 255.
  - Last beat (out_last=1): beat_cnt clears to 0 and frame_cnt increments, wrapping 2^CNT_W-1 -> 0.
  - A fire with out_last=0 while beat_cnt == MAX_BEATS-1 sets err_overlength. beat_cnt keeps saturating until the next last beat.
- err_underflow is set the cycle after fifo_underflow is seen high. Both error flags clear only on rst.
- flush (one or more cycles):
  - fifo_clear equals flush combinationally; fifo_ren is 0.
  - On the next cycle occ=0, out_valid=0 and beat_cnt=0; frame_cnt and the error flags are unchanged.
  - A fire in the same cycle as flush is not counted.
- Protocol: fifo_ren is never high while fifo_empty is high; the bench asserts this every cycle.

Test Plan:
- Reset then idle with fifo_empty=1: fifo_ren, out_valid, all counters and flags stay 0; out_data=0.
- Streaming: push 0x0_0000_0001, 0x0_0000_0002, 0x2_0000_0003 (bit33 set on third) with out_ready=1 -> words emerge in order, one per cycle, first one cycle after non-empty; frame_cnt=1, beat_cnt=0.
- Backpressure: 5 words queued, out_ready=0 for 6 cycles -> occ=2, fifo_ren low after 2 pops, out_data holds the first word. Then release -> all 5 words delivered in order with no loss or duplication.
- Overlength: MAX_BEATS=4, send 5 non-last words then a last word -> err_overlength rises on the 4th fire; frame_cnt=1 afterwards.
- Flush with occ=2 and beat_cnt=1 -> fifo_clear pulses, out_valid=0 next cycle, beat_cnt=0, frame_cnt unchanged. Drive fifo_underflow high 1 cycle -> err_underflow=1, sticky until rst.
- Wrap: CNT_W=2, 4 single-beat frames -> frame_cnt sequence 1,2,3,0. Assert rst mid-frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/nx_fifo_drain.sv
// nx_fifo_drain: read-side consumer for a fall-through FIFO. Pops words into a
// 2-entry skid buffer and presents them as a valid/ready stream. It also tracks
// frame boundaries (per-word last flag), counts beats and frames, and keeps
// sticky underflow / overlength error flags.
module nx_fifo_drain #(
  parameter int DATA_W    = 34,
  parameter int LAST_BIT  = 33,
  parameter int MAX_BEATS = 255,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_underflow,
  output logic              fifo_ren,
  output logic              fifo_clear,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [7:0]        beat_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_underflow,
  output logic              err_overlength
);

  // Beat count at which one more non-last beat makes the frame too long.
  localparam logic [7:0] OVL_AT = 8'(MAX_BEATS - 1);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              err_underflow_q, err_underflow_d;
  logic              err_overlength_q, err_overlength_d;
  logic              fire;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Pop only from registered occupancy so fifo_ren never depends on out_ready.
  assign fifo_ren       = !rst && !flush && !fifo_empty && (occ_q < 2'd2);
  assign fifo_clear     = flush;
  assign out_valid      = (occ_q != 2'd0);
  assign out_data       = out_valid ? head_q : '0;
  assign out_last       = out_data[LAST_BIT];
  // A handshake coinciding with flush is discarded, so it is not a fire.
  assign fire           = out_valid && out_ready && !flush;
  assign beat_cnt       = beat_cnt_q;
  assign frame_cnt      = frame_cnt_q;
  assign err_underflow  = err_underflow_q;
  assign err_overlength = err_overlength_q;

  // Skid buffer next state: capture into tail, remove head on fire, keep order.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({fifo_ren, fire})
        2'b10: begin
          if (occ_q == 2'd0) head_d = fifo_rdata;
          else               tail_d = fifo_rdata;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = fifo_rdata;
          end else begin
            head_d = tail_q;
            tail_d = fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame accounting and sticky error flags.
  always_comb begin
    beat_cnt_d       = beat_cnt_q;
    frame_cnt_d      = frame_cnt_q;
    err_overlength_d = err_overlength_q;
    err_underflow_d  = err_underflow_q | fifo_underflow;
    if (flush) begin
      beat_cnt_d = 8'd0;
    end else if (fire) begin
      if (head_q[LAST_BIT]) begin
        beat_cnt_d  = 8'd0;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        if (beat_cnt_q == OVL_AT) err_overlength_d = 1'b1;
        beat_cnt_d = sat_inc8(beat_cnt_q);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q            <= 2'd0;
      beat_cnt_q       <= 8'd0;
      frame_cnt_q      <= '0;
      err_underflow_q  <= 1'b0;
      err_overlength_q <= 1'b0;
    end else begin
      occ_q            <= occ_d;
      beat_cnt_q       <= beat_cnt_d;
      frame_cnt_q      <= frame_cnt_d;
      err_underflow_q  <= err_underflow_d;
      err_overlength_q <= err_overlength_d;
    end
  end

  // Skid data storage; contents are only observable while occupancy covers them.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: tb/tb_nx_fifo_drain.sv
// Testbench for nx_fifo_drain: a queue models the FIFO read port, a scoreboard
// queue holds words expected on the stream, and a negedge monitor consumes them.
module tb_nx_fifo_drain;

  localparam int DW = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_underflow = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          fifo_ren, fifo_clear, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [7:0]    beat_cnt;
  logic [1:0]    frame_cnt;
  logic          err_underflow, err_overlength;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_w;
  int n_tests = 0;
  int n_fail  = 0;

  nx_fifo_drain #(.DATA_W(DW), .LAST_BIT(33), .MAX_BEATS(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_underflow(fifo_underflow), .fifo_ren(fifo_ren), .fifo_clear(fifo_clear),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .beat_cnt(beat_cnt), .frame_cnt(frame_cnt),
    .err_underflow(err_underflow), .err_overlength(err_overlength)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = (src_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : src_q[0];
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit expct);
    src_q.push_back(w);
    if (expct) exp_q.push_back(w);
    refresh();
  endtask

  // One clock: sample pop/clear before the edge, update the FIFO model after it.
  task automatic tick();
    logic pp, clr;
    logic [DW-1:0] dummy;
    @(negedge clk);
    pp  = fifo_ren;
    clr = fifo_clear;
    @(posedge clk);
    #1;
    if (clr) src_q.delete();
    else if (pp && src_q.size() > 0) dummy = src_q.pop_front();
    refresh();
    #1;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((src_q.size() != 0 || out_valid === 1'b1) && c < maxc) begin
      tick();
      c++;
    end
    check("drain_done", 64'(c < maxc), 64'(1));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on every accepted beat.
  always @(negedge clk) begin
    check("ren_while_empty", 64'(fifo_ren && fifo_empty), 64'(0));
    if (!out_valid) check("data_zero_idle", 64'(out_data), 64'(0));
    if (out_valid && out_ready && !flush && !rst) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
      end else begin
        mon_w = exp_q.pop_front();
        check("stream_word", 64'(out_data), 64'(mon_w));
        check("stream_last", 64'(out_last), 64'(mon_w[33]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  localparam logic [7:0] OV_BEAT [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
  localparam logic       OV_ERR  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [1:0] WRAP_F  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    // Reset and idle with an empty FIFO
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_fifo_ren", 64'(fifo_ren), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_beat", 64'(beat_cnt), 64'(0));
    check("rst_frame", 64'(frame_cnt), 64'(0));
    check("rst_err_uf", 64'(err_underflow), 64'(0));
    check("rst_err_ov", 64'(err_overlength), 64'(0));
    repeat (3) tick();
    check("idle_valid", 64'(out_valid), 64'(0));
    check("idle_ren", 64'(fifo_ren), 64'(0));

    // Streaming three-word frame at full rate
    out_ready = 1'b1;
    push_word(34'h0_0000_0001, 1'b1);
    push_word(34'h0_0000_0002, 1'b1);
    push_word(34'h2_0000_0003, 1'b1);
    #1;
    check("stream_ren_first", 64'(fifo_ren), 64'(1));
    tick();
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_data1", 64'(out_data), 64'h1);
    tick();
    check("tput_data2", 64'(out_data), 64'h2);
    tick();
    check("tput_data3", 64'(out_data), 64'h2_0000_0003);
    check("tput_last3", 64'(out_last), 64'(1));
    tick();
    check("stream_valid_end", 64'(out_valid), 64'(0));
    check("stream_frame", 64'(frame_cnt), 64'(1));
    check("stream_beat", 64'(beat_cnt), 64'(0));

    // Backpressure: five words, out_ready low for six cycles
    do_reset();
    out_ready = 1'b0;
    push_word(34'h0_0000_0010, 1'b1);
    push_word(34'h0_0000_0011, 1'b1);
    push_word(34'h2_0000_0012, 1'b1);
    push_word(34'h0_0000_0013, 1'b1);
    push_word(34'h2_0000_0014, 1'b1);
    tick();
    tick();
    check("bp_ren_stalled", 64'(fifo_ren), 64'(0));
    repeat (4) tick();
    check("bp_valid_held", 64'(out_valid), 64'(1));
    check("bp_data_held", 64'(out_data), 64'h10);
    check("bp_fifo_left", 64'(src_q.size()), 64'(3));
    out_ready = 1'b1;
    drain(20);
    check("bp_frames", 64'(frame_cnt), 64'(2));
    check("bp_beat", 64'(beat_cnt), 64'(0));
    check("bp_err_ov", 64'(err_overlength), 64'(0));

    // Overlength frame with MAX_BEATS=4
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(34'h0_0000_0020 + 34'(i), 1'b1);
    push_word(34'h2_0000_0025, 1'b1);
    tick();
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("ov_beat", 64'(beat_cnt), 64'(OV_BEAT[k]));
      check("ov_err", 64'(err_overlength), 64'(OV_ERR[k]));
    end
    check("ov_frame", 64'(frame_cnt), 64'(1));

    // Flush with two buffered words and one beat into a frame
    do_reset();
    out_ready = 1'b1;
    push_word(34'h2_0000_002F, 1'b1);
    push_word(34'h0_0000_0030, 1'b1);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    push_word(34'h0_0000_0031, 1'b0);
    push_word(34'h0_0000_0032, 1'b0);
    push_word(34'h0_0000_0033, 1'b0);
    tick();
    tick();
    check("fl_pre_data", 64'(out_data), 64'h31);
    check("fl_pre_ren", 64'(fifo_ren), 64'(0));
    check("fl_pre_beat", 64'(beat_cnt), 64'(1));
    check("fl_pre_frame", 64'(frame_cnt), 64'(1));
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("fl_clear", 64'(fifo_clear), 64'(1));
    check("fl_ren", 64'(fifo_ren), 64'(0));
    tick();
    flush = 1'b0;
    #1;
    check("fl_clear_off", 64'(fifo_clear), 64'(0));
    check("fl_valid", 64'(out_valid), 64'(0));
    check("fl_beat", 64'(beat_cnt), 64'(0));
    check("fl_frame", 64'(frame_cnt), 64'(1));
    check("fl_err_ov", 64'(err_overlength), 64'(0));
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    check("uf_set", 64'(err_underflow), 64'(1));
    repeat (3) tick();
    check("uf_sticky", 64'(err_underflow), 64'(1));
    check("uf_idle_valid", 64'(out_valid), 64'(0));

    // Frame counter wrap with CNT_W=2, then reset mid-frame
    do_reset();
    check("wrap_uf_cleared", 64'(err_underflow), 64'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_word(34'h2_0000_0040 + 34'(k), 1'b1);
      tick();
      tick();
      check("wrap_frame", 64'(frame_cnt), 64'(WRAP_F[k]));
    end
    push_word(34'h0_0000_0050, 1'b1);
    push_word(34'h0_0000_0051, 1'b0);
    tick();
    tick();
    check("mid_beat", 64'(beat_cnt), 64'(1));
    check("mid_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b0;
    do_reset();
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_data", 64'(out_data), 64'(0));
    check("mid_rst_beat", 64'(beat_cnt), 64'(0));
    check("mid_rst_frame", 64'(frame_cnt), 64'(0));
    check("mid_rst_err_ov", 64'(err_overlength), 64'(0));

    // beat_cnt saturates at 255 on a very long frame
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) push_word(34'h0_0000_0100 + 34'(i), 1'b1);
    drain(400);
    check("sat_beat", 64'(beat_cnt), 64'(255));
    check("sat_err_ov", 64'(err_overlength), 64'(1));
    push_word(34'h2_0000_0000, 1'b1);
    drain(10);
    check("sat_end_beat", 64'(beat_cnt), 64'(0));
    check("sat_end_frame", 64'(frame_cnt), 64'(1));

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
